// File: rtl/adder_share_ctrl_if.sv
// Bundle between the press/adder/display side and the adder sharing controller.
// The master modport is the controller; the slave modport is its environment.
interface adder_share_ctrl_if #(
  parameter int N = 10
);
  logic [N-1:0]   press;
  logic [3:0]     add_a;
  logic [3:0]     add_b;
  logic [3:0]     add_result;
  logic [4*N-1:0] values_flat;
  logic           sel_valid;
  logic [3:0]     sel_idx;
  logic           busy;
  logic           done;
  logic           cancel;

  modport master (
    input  press, add_result,
    output add_a, add_b, values_flat, sel_valid, sel_idx, busy, done, cancel
  );

  modport slave (
    output press, add_result,
    input  add_a, add_b, values_flat, sel_valid, sel_idx, busy, done, cancel
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Two-press operand selection over N 4-bit cells sharing one registered adder;
// the sum lands in the second-selected cell ADD_LAT+1 clocks after the select.
module adder_share_ctrl #(
  parameter int             N           = 10,
  parameter int             ADD_LAT     = 1,
  parameter int             ARM_TIMEOUT = 0,
  parameter logic [4*N-1:0] INIT_VALUES = {N{4'h1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_share_ctrl_if.master bus
);

  localparam int LW = $clog2(ADD_LAT + 1);
  localparam int TW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, WAIT} state_t;

  state_t         state_q, state_d;
  logic [3:0]     a_idx_q, a_idx_d;
  logic [3:0]     b_idx_q, b_idx_d;
  logic [3:0]     add_a_q, add_a_d;
  logic [3:0]     add_b_q, add_b_d;
  logic [4*N-1:0] values_q, values_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           done_q, done_d;
  logic           cancel_q, cancel_d;
  logic [N-1:0]   masked;

  function automatic logic [3:0] lowest(input logic [N-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] cell_of(input logic [4*N-1:0] v, input logic [3:0] idx);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == 4'(i)) c = v[4*i +: 4];
    end
    return c;
  endfunction

  // Presses other than the held operand; a re-press of A alone means cancel.
  assign masked = bus.press & ~(N'(1) << a_idx_q);

  always_comb begin
    state_d  = state_q;
    a_idx_d  = a_idx_q;
    b_idx_d  = b_idx_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    values_d = values_q;
    lat_d    = lat_q;
    tmr_d    = tmr_q;
    done_d   = 1'b0;
    cancel_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.press) begin
          a_idx_d = lowest(bus.press);
          tmr_d   = TW'(ARM_TIMEOUT);
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (|masked) begin
          b_idx_d = lowest(masked);
          add_a_d = cell_of(values_q, a_idx_q);
          add_b_d = cell_of(values_q, lowest(masked));
          lat_d   = LW'(ADD_LAT);
          state_d = WAIT;
        end else if (|(bus.press & ~masked)) begin
          cancel_d = 1'b1;
          state_d  = IDLE;
        end else if (ARM_TIMEOUT != 0) begin
          if (tmr_q == TW'(1)) begin
            cancel_d = 1'b1;
            state_d  = IDLE;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          for (int i = 0; i < N; i++) begin
            if (b_idx_q == 4'(i)) values_d[4*i +: 4] = bus.add_result;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_idx_q  <= '0;
      b_idx_q  <= '0;
      add_a_q  <= '0;
      add_b_q  <= '0;
      values_q <= INIT_VALUES;
      lat_q    <= '0;
      tmr_q    <= '0;
      done_q   <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_idx_q  <= a_idx_d;
      b_idx_q  <= b_idx_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      values_q <= values_d;
      lat_q    <= lat_d;
      tmr_q    <= tmr_d;
      done_q   <= done_d;
      cancel_q <= cancel_d;
    end
  end

  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.values_flat = values_q;
  assign bus.sel_valid   = (state_q == ARMED);
  assign bus.sel_idx     = (state_q == ARMED) ? a_idx_q : 4'h0;
  assign bus.busy        = (state_q == WAIT);
  assign bus.done        = done_q;
  assign bus.cancel      = cancel_q;

endmodule
